// File: rtl/modulo_carregador_instrucoes.sv
// Instruction loader: assembles MSB-first bytes into words and writes them to
// instruction memory, one write strobe per word, with an inter-byte timeout.
module modulo_carregador_instrucoes #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 13,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [TW-1:0]       TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, FIN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            bidx;
  logic [TW-1:0]         tcnt;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] word_nxt;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;
  logic                  accept;
  logic                  last_byte;
  logic                  timeout;
  logic                  last_word;

  function automatic logic [ADDR_WIDTH:0] sat_count(input logic [ADDR_WIDTH:0] n);
    return (n > MAX_WORDS) ? MAX_WORDS : n;
  endfunction

  // Reset masks every control output combinationally so a WRITE cycle that
  // coincides with rst never produces a strobe.
  assign byte_ready = (state == RECV) && !rst;
  assign we         = (state == WRITE) && !rst;
  assign busy       = (state != IDLE) && !rst;
  assign done       = (state == FIN) && !rst;
  assign error      = err_q && !rst;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;

  assign accept    = byte_ready && byte_valid;
  assign last_byte = accept && (bidx == 2'd3);
  assign timeout   = (state == RECV) && !byte_valid && (tcnt == TO_LAST);
  assign last_word = (remaining == (ADDR_WIDTH+1)'(1));
  assign word_nxt  = {word[DATA_WIDTH-9:0], byte_data};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (num_words == '0) ? FIN : RECV;
      RECV: begin
        if (last_byte)    state_nxt = WRITE;
        else if (timeout) state_nxt = IDLE;
      end
      WRITE: state_nxt = last_word ? FIN : RECV;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      addr      <= '0;
      bidx      <= '0;
      tcnt      <= '0;
      err_q     <= 1'b0;
      word      <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state <= state_nxt;
      err_q <= timeout;

      if (state == IDLE && start) begin
        remaining <= sat_count(num_words);
        addr      <= '0;
        bidx      <= '0;
      end

      // Idle-gap counter only runs while waiting for bytes.
      if (state != RECV || accept) tcnt <= '0;
      else                         tcnt <= tcnt + TW'(1);

      if (accept) begin
        word <= word_nxt;
        bidx <= bidx + 2'd1;
      end

      if (last_byte) begin
        waddr_q <= addr;
        wdata_q <= word_nxt;
      end

      if (timeout) bidx <= '0;

      if (state == WRITE) begin
        addr      <= addr + ADDR_WIDTH'(1);
        remaining <= remaining - (ADDR_WIDTH+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_modulo_carregador_instrucoes.sv
// Bench for the instruction loader: behavioural model checked every cycle,
// directed scenarios with literal expectations, and randomized traffic.
module tb_modulo_carregador_instrucoes;
  localparam int DW = 32;
  localparam int AW = 13;
  localparam int TO = 1000;
  localparam int M_IDLE = 0, M_RECV = 1, M_WRITE = 2, M_FIN = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   num_words = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready, we, busy, done, error;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  int ncmp = 0;
  int nfail = 0;

  modulo_carregador_instrucoes #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      if (nfail <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural reference
  int            m_mode = M_IDLE;
  int            m_left = 0, m_addr = 0, m_nb = 0, m_idle = 0;
  logic [31:0]   m_acc = '0, m_wdata = '0;
  logic [AW-1:0] m_waddr = '0;
  logic          m_err = 1'b0;

  always @(posedge clk) begin : model
    int n;
    logic [31:0] acc;
    if (rst) begin
      m_mode <= M_IDLE; m_err <= 1'b0; m_waddr <= '0; m_wdata <= '0;
      m_acc <= '0; m_nb <= 0; m_idle <= 0; m_left <= 0; m_addr <= 0;
    end else begin
      m_err <= 1'b0;
      case (m_mode)
        M_IDLE: if (start) begin
          n = int'(num_words);
          if (n > (1 << AW)) n = 1 << AW;
          m_left <= n; m_addr <= 0; m_nb <= 0; m_idle <= 0;
          m_mode <= (n == 0) ? M_FIN : M_RECV;
        end
        M_RECV: if (byte_valid) begin
          acc = {m_acc[23:0], byte_data};
          m_acc <= acc; m_idle <= 0;
          if (m_nb == 3) begin
            m_nb <= 0; m_waddr <= m_addr[AW-1:0]; m_wdata <= acc; m_mode <= M_WRITE;
          end else m_nb <= m_nb + 1;
        end else if (m_idle + 1 == TO) begin
          m_err <= 1'b1; m_mode <= M_IDLE; m_nb <= 0;
        end else m_idle <= m_idle + 1;
        M_WRITE: begin
          m_addr <= m_addr + 1; m_left <= m_left - 1; m_idle <= 0;
          m_mode <= (m_left == 1) ? M_FIN : M_RECV;
        end
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  // Per-cycle comparison and write/pulse logging
  int            wcnt = 0, dcnt = 0, ecnt = 0;
  logic [AW-1:0] l_addr = '0, p_addr = '0;
  logic [DW-1:0] l_data = '0, p_data = '0;

  always @(negedge clk) begin
    chk("byte_ready", byte_ready, (m_mode == M_RECV) && !rst);
    chk("we", we, (m_mode == M_WRITE) && !rst);
    chk("busy", busy, (m_mode != M_IDLE) && !rst);
    chk("done", done, (m_mode == M_FIN) && !rst);
    chk("error", error, m_err && !rst);
    chk("waddr", waddr, m_waddr);
    chk("wdata", wdata, m_wdata);
    if (we) begin
      wcnt <= wcnt + 1; p_addr <= l_addr; p_data <= l_data; l_addr <= waddr; l_data <= wdata;
    end
    if (done)  dcnt <= dcnt + 1;
    if (error) ecnt <= ecnt + 1;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int n);
    start = 1'b1; num_words = (AW+1)'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    byte_data = b; byte_valid = 1'b1; k = 0;
    while (!byte_ready && k < 50) begin tick(); k++; end
    if (!byte_ready) chk("byte_ready_wait", 0, 1);
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int limit);
    int k;
    k = 0;
    while (dcnt == d0 && k < limit) begin tick(); k++; end
    chk("done_seen", dcnt - d0, 1);
  endtask

  initial begin
    int w0, d0, e0, k, n;
    logic [31:0] bytes8 [8];
    bytes8 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

    repeat (3) tick();
    chk("rst_busy", busy, 0); chk("rst_ready", byte_ready, 0);
    chk("rst_waddr", waddr, 0); chk("rst_wdata", wdata, 0);
    rst = 1'b0;
    tick();

    // Two words back-to-back
    w0 = wcnt; d0 = dcnt;
    do_start(2);
    for (int i = 0; i < 8; i++) send_byte(bytes8[i][7:0]);
    wait_done(d0, 20);
    chk("b2b_writes", wcnt - w0, 2);
    chk("b2b_addr0", p_addr, 0); chk("b2b_data0", p_data, 32'h12345678);
    chk("b2b_addr1", l_addr, 1); chk("b2b_data1", l_data, 32'h9ABCDEF0);
    tick();
    chk("b2b_busy_end", busy, 0);

    // Zero-length load
    w0 = wcnt;
    do_start(0);
    chk("zero_done", done, 1);
    tick();
    chk("zero_done_off", done, 0); chk("zero_busy", busy, 0);
    chk("zero_nowrite", wcnt - w0, 0);

    // Byte presented during WRITE is dropped
    d0 = dcnt;
    do_start(2);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    byte_valid = 1'b1; byte_data = 8'hEE;
    tick();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_done(d0, 20);
    chk("drop_word0", p_data, 32'h11223344);
    chk("drop_word1", l_data, 32'h01020304);

    // Reset mid-word, then a clean one-word load
    d0 = dcnt; e0 = ecnt;
    do_start(1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", busy, 0); chk("mrst_ready", byte_ready, 0);
    chk("mrst_we", we, 0); chk("mrst_waddr", waddr, 0); chk("mrst_wdata", wdata, 0);
    tick();
    chk("mrst_nopulse", (dcnt - d0) + (ecnt - e0), 0);
    w0 = wcnt; d0 = dcnt;
    do_start(1);
    send_byte(8'hD1); send_byte(8'hE2); send_byte(8'hF3); send_byte(8'h04);
    wait_done(d0, 20);
    chk("mrst_writes", wcnt - w0, 1);
    chk("mrst_addr", l_addr, 0); chk("mrst_data", l_data, 32'hD1E2F304);

    // Timeout after a partial word
    w0 = wcnt; e0 = ecnt;
    do_start(1);
    send_byte(8'h55); send_byte(8'h66);
    k = 0;
    while (ecnt == e0 && k < TO + 20) begin tick(); k++; end
    chk("to_error", ecnt - e0, 1);
    chk("to_nowrite", wcnt - w0, 0);
    chk("to_ready", byte_ready, 0); chk("to_busy", busy, 0);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      do_start($urandom_range(0, 5));
      n = 40 + $urandom_range(0, 30);
      for (int c = 0; c < n; c++) begin
        byte_valid = ($urandom_range(0, 3) != 0);
        byte_data  = 8'($urandom);
        start      = ($urandom_range(0, 9) == 0);
        num_words  = (AW+1)'($urandom_range(0, 5));
        rst        = ($urandom_range(0, 199) == 0);
        if (it % 10 == 3 && c == 10) begin
          byte_valid = 1'b0; start = 1'b0; rst = 1'b0;
          repeat (TO + 2) tick();
        end
        tick();
      end
      start = 1'b0; rst = 1'b0; byte_valid = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Oversized count saturates to the full address space
    w0 = wcnt; d0 = dcnt;
    do_start(9000);
    k = 0;
    byte_valid = 1'b1;
    while (dcnt == d0 && k < 42000) begin
      byte_data = 8'($urandom);
      tick(); k++;
    end
    byte_valid = 1'b0;
    chk("sat_done", dcnt - d0, 1);
    chk("sat_writes", wcnt - w0, 8192);
    chk("sat_last_addr", l_addr, 8191);
    tick();
    chk("sat_busy_end", busy, 0);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/modulo_carregador_instrucoes.md
MODULO_CARREGADOR_INSTRUCOES -- requirements
Module: modulo_carregador_instrucoes

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction word width; fixed at 32, so one word is 4 bytes.
REQ-002 SHALL have parameter ADDR_WIDTH, default 13, instruction memory address width, giving 8K words.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000, maximum idle cycles allowed between accepted bytes.
REQ-004 SHALL have port clk, input, 1 bit: system clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit: begin a load; sampled only in IDLE.
REQ-007 SHALL have port num_words, input, ADDR_WIDTH+1 bits: number of words to load; sampled with start.
REQ-008 SHALL have port byte_valid, input, 1 bit: byte_data holds a valid byte this cycle.
REQ-009 SHALL have port byte_data, input, 8 bits: incoming program byte, most-significant byte first.
REQ-010 SHALL have port byte_ready, output, 1 bit: loader accepts bytes this cycle.
REQ-011 SHALL have port we, output, 1 bit: one-cycle instruction-memory write strobe.
REQ-012 SHALL have port waddr, output, ADDR_WIDTH bits: write address.
REQ-013 SHALL have port wdata, output, DATA_WIDTH bits: instruction word to write.
REQ-014 SHALL have port busy, output, 1 bit: load in progress.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse on successful completion.
REQ-016 SHALL have port error, output, 1 bit: one-cycle pulse on timeout abort.

Function
REQ-017 SHALL implement states IDLE, RECV, WRITE and FIN.
- IDLE, start=1, num_words!=0: go to RECV; latch count; clear word address and byte index to 0.
- IDLE, start=1, num_words=0: go to FIN; perform no write.
REQ-018 SHALL saturate a latched num_words greater than 2**ADDR_WIDTH to 2**ADDR_WIDTH.
REQ-019 SHALL ignore start outside IDLE.
REQ-020 SHALL drive byte_ready=1 only in RECV; a byte is accepted only when byte_valid and byte_ready are both 1; byte_valid while byte_ready=0 is dropped.
REQ-021 SHALL shift each accepted byte in as {word[23:0], byte_data}, so the first byte ends in bits [31:24].
REQ-022 SHALL go from RECV to WRITE on the cycle the 4th byte of a word is accepted; byte index wraps 3->0.
REQ-023 SHALL, in WRITE, hold we=1 for exactly one cycle with waddr = current word address and wdata = the assembled word; 4th byte accepted at edge N -> we high in cycle after N, no more latency.
REQ-024 SHALL, after WRITE, increment the address and decrement the remaining count; go to FIN if remaining is 0, else back to RECV.
REQ-025 SHALL, in FIN, pulse done=1 for one cycle, then go to IDLE.
REQ-026 SHALL drive busy=1 in RECV, WRITE and FIN, else 0.
REQ-027 SHALL keep a timeout counter in RECV.
- Counter clears on each accepted byte and on entry to RECV.
- When the counter reaches TIMEOUT_CYCLES: pulse error for one cycle, discard the partial word, go to IDLE, perform no write.
- Words already written are not rolled back.
REQ-028 SHALL drive we=0 and hold waddr/wdata stable in every state other than WRITE.
REQ-029 SHALL, for an address reaching 2**ADDR_WIDTH-1, complete through saturation of the count; the address never wraps within one load.

Reset
REQ-030 SHALL, while rst=1 at a clock edge, force state IDLE and drive byte_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, error=0; clear all counters.
REQ-031 SHALL let rst abort any load mid-operation with no done or error pulse; a WRITE cycle coinciding with rst produces no write.
REQ-032 SHALL give rst priority over start and byte_valid in the same cycle.

Verification
REQ-033 SHALL be verified by: start, num_words=2, bytes 12 34 56 78 9A BC DE F0 back-to-back -> we at addr 0 with 0x12345678, we at addr 1 with 0x9ABCDEF0, then done pulse, busy=0.
REQ-034 SHALL be verified by: start, num_words=0 -> done one cycle later, we never asserted.
REQ-035 SHALL be verified by: num_words=1, 2 bytes, then silence for 50000 cycles -> error pulse, no we, IDLE, byte_ready=0.
REQ-036 SHALL be verified by: byte_valid held high during the WRITE cycle -> that byte is dropped and the next word starts from the following accepted byte.
REQ-037 SHALL be verified by: rst asserted after 3 bytes of word 0 -> outputs at reset values next edge; a following load of 1 word writes addr 0 correctly.
REQ-038 SHALL be verified by: num_words=9000 -> saturated to 8192; the last write is at addr 8191, then done.
